// File: rtl/adc_access_arbiter_if.sv
// Signal bundle between the requesters, the arbiter and the ADC reader.
// The arbiter uses the slave modport; the environment drives the master side.
interface adc_access_arbiter_if #(
   parameter int unsigned NREQ = 2
);
   logic [NREQ-1:0] req;
   logic [NREQ-1:0] gnt;
   logic [9:0]      rd_data;
   logic            rd_err;
   logic            busy;
   logic            adc_start;
   logic            adc_ready;
   logic [9:0]      adc_data;

   modport master (
      output req, adc_ready, adc_data,
      input  gnt, rd_data, rd_err, busy, adc_start
   );

   modport slave (
      input  req, adc_ready, adc_data,
      output gnt, rd_data, rd_err, busy, adc_start
   );
endinterface

// File: rtl/adc_access_arbiter.sv
// Round-robin arbiter sharing one ADC reader between NREQ requesters; runs one full
// start/ready-low/ready-high conversion per grant, with a watchdog abort on hung conversions.
module adc_access_arbiter #(
   parameter int unsigned NREQ         = 2,
   parameter int unsigned START_CYCLES = 4,
   parameter int unsigned TIMEOUT      = 4096
) (
   input logic                 clk_i,
   input logic                 reset_ni,
   adc_access_arbiter_if.slave bus_io
);
   localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned CntW = $clog2(TIMEOUT) + 1;

   typedef enum logic [2:0] {StIdle, StStart, StWaitLow, StWaitHigh, StDone} state_e;

   state_e          state_q;
   logic [IdxW-1:0] rr_q;
   logic [IdxW-1:0] owner_q;
   logic [IdxW-1:0] pick;
   logic            found;
   logic [3:0]      start_cnt_q;
   logic [CntW-1:0] wdog_q;
   logic [NREQ-1:0] gnt_q;
   logic [9:0]      rd_data_q;
   logic            rd_err_q;
   logic            busy_q;
   logic            adc_start_q;
   logic            timeout_hit;

   // First requester at or after the round-robin pointer, wrapping at NREQ-1.
   always_comb begin
      int unsigned idx;
      pick  = '0;
      found = 1'b0;
      idx   = 0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         idx = 32'(rr_q) + i;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!found && bus_io.req[IdxW'(idx)]) begin
            found = 1'b1;
            pick  = IdxW'(idx);
         end
      end
   end

   assign timeout_hit = (wdog_q == CntW'(TIMEOUT - 1)) &&
                        (state_q inside {StStart, StWaitLow, StWaitHigh});

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q     <= StIdle;
         rr_q        <= '0;
         owner_q     <= '0;
         start_cnt_q <= '0;
         wdog_q      <= '0;
         gnt_q       <= '0;
         rd_data_q   <= '0;
         rd_err_q    <= 1'b0;
         busy_q      <= 1'b0;
         adc_start_q <= 1'b0;
      end else begin
         gnt_q <= '0;
         if (state_q != StIdle) wdog_q <= wdog_q + CntW'(1);
         if (timeout_hit) begin
            adc_start_q    <= 1'b0;
            rd_data_q      <= '0;
            rd_err_q       <= 1'b1;
            gnt_q[owner_q] <= 1'b1;
            state_q        <= StDone;
         end else begin
            unique case (state_q)
               StIdle: begin
                  if (bus_io.adc_ready && found) begin
                     owner_q     <= pick;
                     wdog_q      <= '0;
                     start_cnt_q <= '0;
                     adc_start_q <= 1'b1;
                     busy_q      <= 1'b1;
                     state_q     <= StStart;
                  end
               end
               StStart: begin
                  if (start_cnt_q == 4'(START_CYCLES - 1)) begin
                     adc_start_q <= 1'b0;
                     // Reader may already have dropped ready during the start pulse.
                     state_q     <= bus_io.adc_ready ? StWaitLow : StWaitHigh;
                  end else begin
                     start_cnt_q <= start_cnt_q + 4'd1;
                  end
               end
               StWaitLow: begin
                  if (!bus_io.adc_ready) state_q <= StWaitHigh;
               end
               StWaitHigh: begin
                  if (bus_io.adc_ready) begin
                     rd_data_q      <= bus_io.adc_data;
                     rd_err_q       <= 1'b0;
                     gnt_q[owner_q] <= 1'b1;
                     state_q        <= StDone;
                  end
               end
               StDone: begin
                  rr_q    <= (owner_q == IdxW'(NREQ - 1)) ? '0 : owner_q + IdxW'(1);
                  busy_q  <= 1'b0;
                  state_q <= StIdle;
               end
               default: state_q <= StIdle;
            endcase
         end
      end
   end

   assign bus_io.gnt       = gnt_q;
   assign bus_io.rd_data   = rd_data_q;
   assign bus_io.rd_err    = rd_err_q;
   assign bus_io.busy      = busy_q;
   assign bus_io.adc_start = adc_start_q;

endmodule
